// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit multi-cycle CPU sequencer.
// Opcodes, FSM states, IR field positions and the decode bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALTED
    } state_e;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_ADDI = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam int OP_LSB  = 12;
    localparam int TYPE_B  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS_LSB  = 5;
    localparam int RM_LSB  = 2;
    localparam int IMM_W   = 5;

    typedef struct packed {
        logic [2:0]  rs;
        logic [2:0]  rm;
        logic [2:0]  rd;
        logic [15:0] imm_n;
        logic        is_alu;
        logic        is_halt;
        logic        is_illegal;
    } dec_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction fetch port: req/ack handshake with a 16-bit address and data.
// The sequencer is the master, instruction memory the slave.
interface cpu_sequencer_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decode: IR -> register fields, immediate, class.
// Kept separate so later forwarding logic can reuse the same decode.
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output dec_t        dec_o
);

    logic [3:0] op;

    assign op = ir_i[OP_LSB +: 4];

    always_comb begin
        dec_o            = '0;
        dec_o.rd         = ir_i[RD_LSB +: 3];
        dec_o.rs         = ir_i[RS_LSB +: 3];
        dec_o.rm         = ir_i[RM_LSB +: 3];
        dec_o.imm_n      = sext5(ir_i[IMM_W-1:0]);
        unique case (1'b1)
            (op == OP_ADD),
            (op == OP_ADDI): dec_o.is_alu  = 1'b1;
            (op == OP_HALT): dec_o.is_halt = 1'b1;
            (op == OP_NOP):  ;
            default:         dec_o.is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, decode, execute, writeback, halt.
// Owns PC, IR, the ALU result register and the fetch timeout counter.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] PC_RESET    = 16'h0000,
    parameter int          ACK_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    cpu_sequencer_if.master mem,
    output logic [15:0]  instruction,
    output logic [2:0]   rf_raddr_s,
    output logic [2:0]   rf_raddr_m,
    output logic [15:0]  imm_n,
    input  logic [15:0]  aluout,
    output logic         rf_we,
    output logic [2:0]   rf_waddr,
    output logic [15:0]  rf_wdata,
    output logic [15:0]  pc,
    output logic         halted,
    output logic         bus_error,
    output logic         illegal
);

    localparam logic [7:0] TMO_LAST = 8'(ACK_TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] res_q;
    logic [7:0]  cnt_q;
    logic        req_q;
    logic        we_q;
    logic        ill_q;
    logic        halt_q;
    logic        berr_q;
    dec_t        dec;

    cpu_decode u_dec (
        .ir_i  (ir_q),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            pc_q    <= PC_RESET;
            ir_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            ill_q   <= 1'b0;
            halt_q  <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            we_q  <= 1'b0;
            ill_q <= 1'b0;
            unique case (state_q)
                S_FETCH: begin
                    // run only gates the start of a fetch, never aborts one
                    if (!req_q) begin
                        req_q <= run;
                        cnt_q <= '0;
                    end else if (mem.mem_ack) begin
                        ir_q    <= mem.mem_rdata;
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_DECODE;
                    end else if (cnt_q == TMO_LAST) begin
                        req_q   <= 1'b0;
                        berr_q  <= 1'b1;
                        halt_q  <= 1'b1;
                        state_q <= S_HALTED;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_DECODE: state_q <= S_EXECUTE;
                S_EXECUTE: begin
                    res_q   <= aluout;
                    we_q    <= dec.is_alu;
                    ill_q   <= dec.is_illegal;
                    state_q <= S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (dec.is_halt) begin
                        halt_q  <= 1'b1;
                        state_q <= S_HALTED;
                    end else begin
                        pc_q    <= pc_q + 16'd1;
                        req_q   <= run;
                        state_q <= S_FETCH;
                    end
                end
                S_HALTED: req_q <= 1'b0;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = pc_q;
    assign instruction  = ir_q;
    assign rf_raddr_s   = dec.rs;
    assign rf_raddr_m   = dec.rm;
    assign imm_n        = dec.imm_n;
    assign rf_we        = we_q;
    assign rf_waddr     = dec.rd;
    assign rf_wdata     = res_q;
    assign pc           = pc_q;
    assign halted       = halt_q;
    assign bus_error    = berr_q;
    assign illegal      = ill_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench: random programs run through an ISA-level model;
// a monitor compares every fetch address and writeback against it.
module tb_cpu_sequencer;

    localparam logic [15:0] PCR = 16'hFFFE;
    localparam int          TMO = 8;
    localparam int          NPROG = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic [15:0] instruction;
    logic [2:0]  rf_raddr_s;
    logic [2:0]  rf_raddr_m;
    logic [15:0] imm_n;
    logic [15:0] aluout;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] pc;
    logic        halted;
    logic        bus_error;
    logic        illegal;

    cpu_sequencer_if mif ();

    cpu_sequencer #(
        .PC_RESET    (PCR),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .mem         (mif.master),
        .instruction (instruction),
        .rf_raddr_s  (rf_raddr_s),
        .rf_raddr_m  (rf_raddr_m),
        .imm_n       (imm_n),
        .aluout      (aluout),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pc          (pc),
        .halted      (halted),
        .bus_error   (bus_error),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  rd;
        logic [15:0] val;
        logic        ill;
    } ev_t;

    logic [15:0] mem [256];
    logic [15:0] rf [8];
    logic [15:0] fq [$];
    ev_t         evq [$];
    int checks = 0;
    int failures = 0;
    int max_delay = 0;
    int cur_delay = 0;
    int wait_cnt = 0;
    int delay_sum = 0;
    bit no_ack = 1'b0;

    function automatic logic [15:0] rf_init(input int i);
        case (i)
            2:       return 16'd5;
            3:       return 16'd7;
            default: return 16'(i * 4097 + 3);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= rf_init(i);
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wdata;
        end
    end

    always_comb begin
        aluout = rf[rf_raddr_s] + rf[rf_raddr_m];
        if (instruction[15:12] == 4'b1001)
            aluout = rf[rf_raddr_s] + imm_n;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s unexpected event", name);
    endtask

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    // memory responder: acks after cur_delay wait cycles
    initial begin
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        forever begin
            @(negedge clk);
            mif.mem_ack = 1'b0;
            if (!rst_n) begin
                wait_cnt = 0;
            end else if (mif.mem_req && !no_ack) begin
                if (wait_cnt >= cur_delay) begin
                    mif.mem_ack   = 1'b1;
                    mif.mem_rdata = mem[mif.mem_addr[7:0]];
                    delay_sum += cur_delay;
                    wait_cnt  = 0;
                    cur_delay = $urandom_range(max_delay, 0);
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin : monitor
        ev_t         e;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n) begin
                if (mif.mem_req && mif.mem_ack) begin
                    if (fq.size() == 0) fail_now("fetch_extra");
                    else begin
                        a = fq.pop_front();
                        check("fetch_addr", 32'(mif.mem_addr), 32'(a));
                    end
                end
                if (rf_we || illegal) begin
                    if (evq.size() == 0) fail_now("wb_extra");
                    else begin
                        e = evq.pop_front();
                        check("wb_we", 32'(rf_we), 32'(!e.ill));
                        check("wb_illegal", 32'(illegal), 32'(e.ill));
                        if (!e.ill) begin
                            check("wb_addr", 32'(rf_waddr), 32'(e.rd));
                            check("wb_data", 32'(rf_wdata), 32'(e.val));
                        end
                    end
                end
            end
        end
    end

    function automatic logic [15:0] enc_add(input logic [2:0] rd,
        input logic [2:0] rs, input logic [2:0] rm);
        return {4'b1000, 1'b0, rd, rs, rm, 2'b00};
    endfunction

    function automatic logic [15:0] enc_addi(input logic [2:0] rd,
        input logic [2:0] rs, input logic [4:0] imm);
        return {4'b1001, 1'b1, rd, rs, imm};
    endfunction

    function automatic logic [15:0] rand_instr();
        int          k;
        logic [3:0]  op;
        k = $urandom_range(9, 0);
        if (k < 4)
            return enc_add(3'($urandom), 3'($urandom), 3'($urandom));
        if (k < 8)
            return enc_addi(3'($urandom), 3'($urandom), 5'($urandom));
        if (k == 8)
            return {4'b0000, 12'($urandom)};
        do op = 4'($urandom_range(14, 1));
        while (op == 4'b1000 || op == 4'b1001);
        return {op, 12'($urandom)};
    endfunction

    // ISA-level run of mem from start; fills fetch and writeback queues
    task automatic build_expect(input logic [15:0] start,
                                output logic [15:0] halt_pc);
        logic [15:0] r [8];
        logic [15:0] p, w;
        ev_t         e;
        for (int i = 0; i < 8; i++) r[i] = rf_init(i);
        p = start;
        halt_pc = 16'hxxxx;
        for (int k = 0; k < 256; k++) begin
            fq.push_back(p);
            w = mem[p[7:0]];
            e = '0;
            case (w[15:12])
                4'b1000: begin
                    r[w[10:8]] = r[w[7:5]] + r[w[4:2]];
                    e.rd = w[10:8];
                    e.val = r[w[10:8]];
                    evq.push_back(e);
                end
                4'b1001: begin
                    r[w[10:8]] = r[w[7:5]] + {{11{w[4]}}, w[4:0]};
                    e.rd = w[10:8];
                    e.val = r[w[10:8]];
                    evq.push_back(e);
                end
                4'b1111: begin
                    halt_pc = p;
                    return;
                end
                4'b0000: ;
                default: begin
                    e.ill = 1'b1;
                    evq.push_back(e);
                end
            endcase
            p = p + 16'd1;
        end
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_mem_req"}, 32'(mif.mem_req), 32'd0);
        check({tag, "_pc"}, 32'(pc), 32'(PCR));
        check({tag, "_rf_we"}, 32'(rf_we), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_bus_error"}, 32'(bus_error), 32'd0);
        check({tag, "_illegal"}, 32'(illegal), 32'd0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] halt_pc;
        logic [15:0] p;
        int          cyc;
        int          seen;
        ev_t         e;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst_n = 1'b0;
        run   = 1'b0;
        repeat (2) tick();
        reset_checks("rst");
        check("rst_instruction", 32'(instruction), 32'd0);

        // program: directed head, random body, HALT at the end
        for (int k = 0; k < NPROG; k++) begin
            p = PCR + 16'(k);
            mem[p[7:0]] = rand_instr();
        end
        mem[8'hFE] = enc_add(3'd1, 3'd2, 3'd3);
        mem[8'hFF] = enc_addi(3'd4, 3'd2, 5'b11111);
        mem[8'h00] = 16'h0000;
        mem[8'h01] = 16'h5123;
        p = PCR + 16'(NPROG - 1);
        mem[p[7:0]] = 16'hF000;
        build_expect(PCR, halt_pc);

        max_delay = 3;
        cur_delay = 0;
        delay_sum = 0;
        rst_n = 1'b1;
        run   = 1'b1;
        cyc = 0;
        while (!mif.mem_req && cyc < 10) begin tick(); cyc++; end
        check("first_req_seen", 32'(mif.mem_req), 32'd1);
        cyc = 1;
        while (!rf_we && cyc < 20) begin tick(); cyc++; end
        check("first_retire_cycle", 32'(cyc), 32'd4);
        while (!halted && cyc < 3000) begin tick(); cyc++; end
        check("halt_cycles", 32'(cyc), 32'(1 + 4 * NPROG + delay_sum));
        check("halt_pc", 32'(pc), 32'(halt_pc));
        check("halt_bus_error", 32'(bus_error), 32'd0);
        seen = 0;
        repeat (10) begin tick(); if (mif.mem_req) seen++; end
        check("halt_no_req", 32'(seen), 32'd0);
        check("halt_sticky", 32'(halted), 32'd1);
        check("prog_fetch_left", 32'(fq.size()), 32'd0);
        check("prog_wb_left", 32'(evq.size()), 32'd0);

        // run gating: idle while low, finish a fetch already issued
        rst_n = 1'b0;
        run   = 1'b0;
        fq.delete();
        evq.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        max_delay = 0;
        cur_delay = 2;
        fq.push_back(PCR);
        e = '0;
        e.rd = 3'd1;
        e.val = 16'd12;
        evq.push_back(e);
        seen = 0;
        repeat (5) begin tick(); if (mif.mem_req) seen++; end
        check("run_low_no_req", 32'(seen), 32'd0);
        check("run_low_pc", 32'(pc), 32'(PCR));
        run = 1'b1;
        cyc = 0;
        while (!mif.mem_req && cyc < 10) begin tick(); cyc++; end
        run = 1'b0;
        repeat (15) tick();
        check("run_drop_wb_left", 32'(evq.size()), 32'd0);
        check("run_drop_fetch_left", 32'(fq.size()), 32'd0);
        check("run_drop_pc", 32'(pc), 32'(PCR + 16'd1));
        check("run_drop_idle", 32'(mif.mem_req), 32'd0);

        // asynchronous reset in the middle of a fetch
        rst_n  = 1'b0;
        run    = 1'b1;
        no_ack = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        cyc = 0;
        while (!mif.mem_req && cyc < 10) begin tick(); cyc++; end
        tick();
        #1 rst_n = 1'b0;
        #1;
        reset_checks("midrst");

        // fetch timeout
        tick();
        rst_n = 1'b1;
        cyc = 0;
        while (!mif.mem_req && cyc < 10) begin tick(); cyc++; end
        seen = 0;
        while (mif.mem_req && seen < 50) begin seen++; tick(); end
        check("tmo_req_cycles", 32'(seen), 32'(TMO));
        check("tmo_bus_error", 32'(bus_error), 32'd1);
        check("tmo_halted", 32'(halted), 32'd1);
        repeat (5) tick();
        check("tmo_sticky_err", 32'(bus_error), 32'd1);
        check("tmo_sticky_req", 32'(mif.mem_req), 32'd0);
        rst_n = 1'b0;
        tick();
        check("tmo_rst_err", 32'(bus_error), 32'd0);
        check("tmo_rst_halt", 32'(halted), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
